// File: rtl/omi_lane_phy_model.sv
// Purpose: one-lane 64b/66b channel model with bit misalignment and rx_slip window shifting.
// Latency: 2*BEATS advancing cycles from tx beat 0 to rx beat 0 at offset 0.
// Backpressure: tx_en low or tx_seq==2'b11 freezes all state; rx_valid is low on those cycles.
// OMI_PHY_MODEL_ERRINJ_EN adds periodic header corruption and the err_inj output.
module omi_lane_phy_model #(
    parameter int PHY_BITS     = 8,
    parameter int INIT_OFFSET  = 0,
`ifdef OMI_PHY_MODEL_ERRINJ_EN
    parameter int SLIP_HOLDOFF = 2,
    parameter int ERR_PERIOD   = 1024
`else
    parameter int SLIP_HOLDOFF = 2
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_en,
    input  logic [PHY_BITS-1:0] tx_data,
    input  logic [1:0]          tx_header,
    input  logic [1:0]          tx_seq,
    input  logic                rx_slip,
    output logic                rx_valid,
    output logic [1:0]          rx_header,
    output logic [PHY_BITS-1:0] rx_data,
    output logic [6:0]          cur_offset,
`ifdef OMI_PHY_MODEL_ERRINJ_EN
    output logic [15:0]         slip_cnt,
    output logic                err_inj
`else
    output logic [15:0]         slip_cnt
`endif
);

    localparam int BEATS = 64 / PHY_BITS;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] tb_q;
    logic [65:0]   asm_q, asm_n, blk_prev, blk_cur, rx_blk, ab, rx_blk_n;
    logic [131:0]  win;
    logic [1:0]    fill;
    logic [6:0]    ofs_q, ofs_n;
    logic          pending;
    logic [3:0]    holdoff;
    logic          adv, blk_done, slip_acc;

    assign adv      = tx_en && (tx_seq != 2'b11);
    assign blk_done = adv && (int'(tb_q) == BEATS - 1);
    assign slip_acc = adv && rx_slip && (holdoff == 4'd0) && !pending;

    // A pending slip moves the offset before the new window is sampled.
    always_comb begin
        asm_n = asm_q;
        if (tb_q == '0) asm_n[65:64] = tx_header;
        asm_n[63 - int'(tb_q) * PHY_BITS -: PHY_BITS] = tx_data;
        ofs_n = ofs_q;
        if (pending) ofs_n = (ofs_q == 7'd65) ? 7'd0 : ofs_q + 7'd1;
        win = {blk_cur, asm_n};
        ab  = win[131 - int'(ofs_n) -: 66];
    end

`ifdef OMI_PHY_MODEL_ERRINJ_EN
    logic [31:0] err_cnt;
    logic        err_flag, err_hit;

    assign err_hit  = (fill != 2'd0) && (err_cnt == 32'(ERR_PERIOD - 1));
    assign rx_blk_n = err_hit ? (ab ^ {1'b1, 65'd0}) : ab;
    assign err_inj  = rx_valid && (tb_q == '0) && err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (blk_done && fill != 2'd0) begin
            err_cnt  <= err_hit ? 32'd0 : err_cnt + 32'd1;
            err_flag <= err_hit;
        end
    end
`else
    assign rx_blk_n = ab;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_q     <= '0;
            asm_q    <= '0;
            blk_prev <= '0;
            blk_cur  <= '0;
            rx_blk   <= '0;
            fill     <= 2'd0;
            ofs_q    <= 7'(INIT_OFFSET);
            pending  <= 1'b0;
            holdoff  <= 4'd0;
            slip_cnt <= 16'd0;
        end else if (adv) begin
            tb_q  <= (int'(tb_q) == BEATS - 1) ? '0 : tb_q + 1'b1;
            asm_q <= asm_n;
            if (blk_done) begin
                blk_prev <= blk_cur;
                blk_cur  <= asm_n;
                fill     <= (fill == 2'd2) ? 2'd2 : fill + 2'd1;
                ofs_q    <= ofs_n;
                rx_blk   <= rx_blk_n;
                pending  <= 1'b0;
                if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
            end
            // Acceptance on a completion cycle overrides the decrement above.
            if (slip_acc) begin
                pending <= 1'b1;
                holdoff <= 4'(SLIP_HOLDOFF);
                if (slip_cnt != 16'hFFFF) slip_cnt <= slip_cnt + 16'd1;
            end
        end
    end

    // The rx beat counter is locked to the tx beat counter, so one register serves both.
    always_comb begin
        rx_valid  = adv && (fill == 2'd2);
        rx_header = 2'b00;
        rx_data   = '0;
        if (fill == 2'd2) begin
            rx_header = rx_blk[65:64];
            rx_data   = rx_blk[63 - int'(tb_q) * PHY_BITS -: PHY_BITS];
        end
    end

    assign cur_offset = ofs_q;

endmodule

// File: tb/tb_omi_lane_phy_model.sv
// Directed bench: two lanes (offset 0 and offset 3) share one tx stream, each with its own slip line.
module tb_omi_lane_phy_model;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic [1:0] tx_header = 2'b00;
    logic [1:0] tx_seq = 2'b00;
    logic       rx_slip0 = 1'b0, rx_slip3 = 1'b0;

    logic       rx_valid0, rx_valid3;
    logic [1:0] rx_header0, rx_header3;
    logic [7:0] rx_data0, rx_data3;
    logic [6:0] cur_offset0, cur_offset3;
    logic [15:0] slip_cnt0, slip_cnt3;

    always #5 clk = ~clk;

    omi_lane_phy_model #(.PHY_BITS(8), .INIT_OFFSET(0), .SLIP_HOLDOFF(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_data(tx_data), .tx_header(tx_header),
        .tx_seq(tx_seq), .rx_slip(rx_slip0), .rx_valid(rx_valid0), .rx_header(rx_header0),
        .rx_data(rx_data0), .cur_offset(cur_offset0), .slip_cnt(slip_cnt0));

    omi_lane_phy_model #(.PHY_BITS(8), .INIT_OFFSET(3), .SLIP_HOLDOFF(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_data(tx_data), .tx_header(tx_header),
        .tx_seq(tx_seq), .rx_slip(rx_slip3), .rx_valid(rx_valid3), .rx_header(rx_header3),
        .rx_data(rx_data3), .cur_offset(cur_offset3), .slip_cnt(slip_cnt3));

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] pat = 64'h0123456789ABCDEF;
    int beat = 0;
    int blk_idx = 0;
    bit alt_hdr = 1'b0;
    logic [1:0] hdr_cur = 2'b01;
    logic [1:0] hdr_hist [0:1023];
    logic       o_vld0, o_vld3;
    logic [7:0] o_dat0, o_dat3;
    logic [1:0] o_hdr0, o_hdr3;
    logic       any_vld;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int k);
        return pat[63 - 8 * k -: 8];
    endfunction

    // mode 0: advance, 1: tx_seq stall, 2: tx_en low
    task automatic cyc(input int mode, input logic s0, input logic s3);
        if (beat == 0) hdr_cur = (alt_hdr && (blk_idx % 2 == 1)) ? 2'b10 : 2'b01;
        tx_en     = (mode != 2);
        tx_seq    = (mode == 1) ? 2'b11 : 2'b00;
        tx_header = hdr_cur;
        tx_data   = pat_byte(beat);
        rx_slip0  = s0;
        rx_slip3  = s3;
        @(negedge clk);
        o_vld0 = rx_valid0; o_dat0 = rx_data0; o_hdr0 = rx_header0;
        o_vld3 = rx_valid3; o_dat3 = rx_data3; o_hdr3 = rx_header3;
        @(posedge clk);
        #1;
        if (mode == 0) begin
            if (beat == 0) hdr_hist[blk_idx] = hdr_cur;
            beat = (beat + 1) % 8;
            if (beat == 0) blk_idx++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; tx_en = 1'b0; tx_seq = 2'b00; rx_slip0 = 1'b0; rx_slip3 = 1'b0;
        alt_hdr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat = 0;
        blk_idx = 0;
    endtask

    initial begin
        apply_reset();
        check("rst_vld", rx_valid0, 1'b0);
        check("rst_hdr", rx_header0, 2'b00);
        check("rst_dat", rx_data0, 8'h00);
        check("rst_ofs0", cur_offset0, 7'd0);
        check("rst_ofs3", cur_offset3, 7'd3);
        check("rst_slips", slip_cnt0, 16'd0);

        // First rx beat appears 16 advancing cycles after tx beat 0.
        any_vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc(0, 1'b0, 1'b0);
            any_vld |= o_vld0;
        end
        check("lat_early_vld", any_vld, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1'b0, 1'b0);
            check("a_vld", o_vld0, 1'b1);
            check("a_dat", o_dat0, pat_byte(k));
            if (k == 0) begin
                check("a_hdr", o_hdr0, 2'b01);
                check("ofs3_hdr", o_hdr3, 2'b00);
                check("ofs3_dat", o_dat3, 8'h09);
            end
        end

        // Offset-3 lane: 63 slips, one per three blocks, wraps the offset back to 0.
        alt_hdr = 1'b1;
        for (int i = 0; i < 63; i++) begin
            cyc(0, 1'b0, 1'b1);
            repeat (23) cyc(0, 1'b0, 1'b0);
        end
        check("wrap_ofs3", cur_offset3, 7'd0);
        check("wrap_slips3", slip_cnt3, 16'd63);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1'b0, 1'b0);
            check("wrap_dat3", o_dat3, pat_byte(k));
            if (k == 0) begin
                check("wrap_hdr3", o_hdr3, hdr_hist[blk_idx - 2]);
                check("alt_hdr0", o_hdr0, hdr_hist[blk_idx - 2]);
            end
            if (k == 4) check("alt_hdr0_hold", o_hdr0, hdr_hist[blk_idx - 2]);
        end

        // rx_slip held for 20 cycles from beat 0: accepted at cycle 0 and again at cycle 16.
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1'b1, 1'b0);
            if (k == 0) begin
                check("hold_cnt0", slip_cnt0, 16'd1);
                check("hold_ofs0", cur_offset0, 7'd0);
            end
            if (k == 7) check("hold_ofs7", cur_offset0, 7'd1);
            if (k == 15) check("hold_cnt15", slip_cnt0, 16'd1);
        end
        check("hold_cnt20", slip_cnt0, 16'd2);
        check("hold_ofs20", cur_offset0, 7'd1);
        repeat (4) cyc(0, 1'b0, 1'b0);
        check("hold_ofs24", cur_offset0, 7'd2);

        // Asynchronous reset in the middle of a block.
        repeat (4) cyc(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_vld", rx_valid0, 1'b0);
        check("mrst_hdr", rx_header0, 2'b00);
        check("mrst_dat", rx_data0, 8'h00);
        check("mrst_ofs0", cur_offset0, 7'd0);
        check("mrst_ofs3", cur_offset3, 7'd3);
        check("mrst_slips", slip_cnt0, 16'd0);
        apply_reset();
        any_vld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc(0, 1'b0, 1'b0);
            any_vld |= o_vld0;
        end
        check("mrst_early_vld", any_vld, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("mrst_first_vld", o_vld0, 1'b1);
        check("mrst_first_dat", o_dat0, 8'h01);

        // Alternate stall cycles: latency doubles, stalls never show valid data.
        apply_reset();
        begin
            logic any_stall;
            any_stall = 1'b0;
            any_vld = 1'b0;
            for (int k = 0; k < 24; k++) begin
                cyc(0, 1'b0, 1'b0);
                if (k < 16) any_vld |= o_vld0;
                else begin
                    check("stall_vld", o_vld0, 1'b1);
                    check("stall_dat", o_dat0, pat_byte(k - 16));
                    if (k == 16) check("stall_hdr", o_hdr0, 2'b01);
                end
                cyc(1, 1'b0, 1'b0);
                any_stall |= o_vld0;
            end
            check("stall_early_vld", any_vld, 1'b0);
            check("stall_cycle_vld", any_stall, 1'b0);
        end
        cyc(2, 1'b0, 1'b0);
        check("txen_low_vld", o_vld0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("txen_resume_vld", o_vld0, 1'b1);
        check("txen_resume_dat", o_dat0, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
